// File: rtl/fetch_decode_buf.sv
// Fetch-to-decode instruction FIFO with valid/ready head and redirect flush.
// Optional same-cycle bypass of an empty buffer: define FETCH_BUF_BYPASS_EN.
module fetch_decode_buf #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_i_valid,
  input  logic [WIDTH-1:0]         fetch_i_pc,
  input  logic [WIDTH-1:0]         fetch_i_pre_pc,
  input  logic [WIDTH-1:0]         fetch_i_instr,
  input  logic                     fetch_i_commit,
  output logic                     fetch_o_ready,
  input  logic                     ctrl_i_flush,
  input  logic                     decode_i_ready,
  output logic                     regD_o_valid,
  output logic [WIDTH-1:0]         regD_o_pc,
  output logic [WIDTH-1:0]         regD_o_pre_pc,
  output logic [WIDTH-1:0]         regD_o_instr,
  output logic                     regD_o_commit,
  output logic [$clog2(DEPTH):0]   buf_o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 3 * WIDTH + 1;

  logic [EW-1:0] mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;

  logic          full, empty;
  logic          push, pop;
  logic          do_write, do_read;
  logic          bypass_active;
  logic [EW-1:0] fetch_entry, head_entry;
  logic [DEPTH-1:0] wr_sel;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign fetch_o_ready = !full;

  assign fetch_entry = {fetch_i_pc, fetch_i_pre_pc, fetch_i_instr, fetch_i_commit};

`ifdef FETCH_BUF_BYPASS_EN
  assign bypass_active = empty && fetch_i_valid && !ctrl_i_flush;
  assign regD_o_valid  = !ctrl_i_flush && (!empty || bypass_active);
  assign head_entry    = bypass_active ? fetch_entry : mem_reg[rd_ptr_reg];
`else
  assign bypass_active = 1'b0;
  assign regD_o_valid  = !empty;
  assign head_entry    = mem_reg[rd_ptr_reg];
`endif

  assign push = fetch_i_valid && fetch_o_ready && !ctrl_i_flush;
  assign pop  = regD_o_valid && decode_i_ready && !ctrl_i_flush;

  // A bypassed entry consumed by decode never touches storage or pointers.
  assign do_write = push && !(bypass_active && decode_i_ready);
  assign do_read  = pop && !bypass_active;

  assign {regD_o_pc, regD_o_pre_pc, regD_o_instr, regD_o_commit} = head_entry;
  assign buf_o_count = count_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = do_write && (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({do_write, do_read})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) mem_reg[i] <= fetch_entry;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (ctrl_i_flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_write) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_read)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_fetch_decode_buf.sv
// Directed bench for fetch_decode_buf (DEPTH=2): reset, fill, stream, flush.
// The bypass scenario runs when FETCH_BUF_BYPASS_EN is defined.
module tb_fetch_decode_buf;

  localparam int DEPTH = 2;
  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_i_valid;
  logic [WIDTH-1:0]  fetch_i_pc, fetch_i_pre_pc, fetch_i_instr;
  logic              fetch_i_commit;
  logic              fetch_o_ready;
  logic              ctrl_i_flush;
  logic              decode_i_ready;
  logic              regD_o_valid;
  logic [WIDTH-1:0]  regD_o_pc, regD_o_pre_pc, regD_o_instr;
  logic              regD_o_commit;
  logic [$clog2(DEPTH):0] buf_o_count;

  int checks = 0;
  int failures = 0;

  fetch_decode_buf #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_i_valid  (fetch_i_valid),
    .fetch_i_pc     (fetch_i_pc),
    .fetch_i_pre_pc (fetch_i_pre_pc),
    .fetch_i_instr  (fetch_i_instr),
    .fetch_i_commit (fetch_i_commit),
    .fetch_o_ready  (fetch_o_ready),
    .ctrl_i_flush   (ctrl_i_flush),
    .decode_i_ready (decode_i_ready),
    .regD_o_valid   (regD_o_valid),
    .regD_o_pc      (regD_o_pc),
    .regD_o_pre_pc  (regD_o_pre_pc),
    .regD_o_instr   (regD_o_instr),
    .regD_o_commit  (regD_o_commit),
    .buf_o_count    (buf_o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Instruction word and commit flag are derived from the pc so each entry is unique.
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h0000_0013;
  endfunction

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, ".valid"},  {31'd0, regD_o_valid}, 32'd1);
    chk({tag, ".pc"},     regD_o_pc, pc);
    chk({tag, ".pre_pc"}, regD_o_pre_pc, pc + 32'd4);
    chk({tag, ".instr"},  regD_o_instr, instr_of(pc));
    chk({tag, ".commit"}, {31'd0, regD_o_commit}, {31'd0, pc[2]});
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later, then idle inputs.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    fetch_i_valid  = v;
    fetch_i_pc     = pc;
    fetch_i_pre_pc = pc + 32'd4;
    fetch_i_instr  = instr_of(pc);
    fetch_i_commit = pc[2];
    decode_i_ready = rdy;
    ctrl_i_flush   = fl;
    @(posedge clk);
    #1;
    fetch_i_valid  = 1'b0;
    decode_i_ready = 1'b0;
    ctrl_i_flush   = 1'b0;
    $display("cyc v=%0b pc=%h rdy=%0b flush=%0b -> valid=%0b head=%h count=%0d ready=%0b",
             v, pc, rdy, fl, regD_o_valid, regD_o_pc, buf_o_count, fetch_o_ready);
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic v, input logic rdy);
    chk({tag, ".count"}, {30'd0, buf_o_count}, 32'(cnt));
    chk({tag, ".valid"}, {31'd0, regD_o_valid}, {31'd0, v});
    chk({tag, ".ready"}, {31'd0, fetch_o_ready}, {31'd0, rdy});
  endtask

  initial begin
    rst = 1'b1;
    fetch_i_valid = 1'b0; fetch_i_pc = '0; fetch_i_pre_pc = '0; fetch_i_instr = '0;
    fetch_i_commit = 1'b0; ctrl_i_flush = 1'b0; decode_i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk_state("reset", 0, 1'b0, 1'b1);
    chk("reset.pc", regD_o_pc, 32'd0);

`ifdef FETCH_BUF_BYPASS_EN
    // Empty buffer, fetch and decode both ready: entry passes straight through.
    fetch_i_valid = 1'b1; fetch_i_pc = 32'h8000_0040; fetch_i_pre_pc = 32'h8000_0044;
    fetch_i_instr = 32'h0000_0013; fetch_i_commit = 1'b1; decode_i_ready = 1'b1;
    #1;
    chk("bypass.instr", regD_o_instr, 32'h0000_0013);
    chk("bypass.valid", {31'd0, regD_o_valid}, 32'd1);
    @(posedge clk);
    #1;
    fetch_i_valid = 1'b0; decode_i_ready = 1'b0;
    chk("bypass.count", {30'd0, buf_o_count}, 32'd0);
    chk("bypass.after_valid", {31'd0, regD_o_valid}, 32'd0);
`endif

    // Fill to DEPTH with decode stalled.
    cyc(1'b1, 32'h8000_0000, 1'b0, 1'b0);
    chk_state("fill1", 1, 1'b1, 1'b1);
    chk_head("fill1", 32'h8000_0000);
    cyc(1'b1, 32'h8000_0004, 1'b0, 1'b0);
    chk_state("fill2", 2, 1'b1, 1'b0);
    chk_head("fill2", 32'h8000_0000);
    cyc(1'b1, 32'h8000_0008, 1'b0, 1'b0);
    chk_state("full_push", 2, 1'b1, 1'b0);
    chk_head("full_push", 32'h8000_0000);

    // Full buffer refuses a push even while decode pops.
    cyc(1'b1, 32'h8000_0008, 1'b1, 1'b0);
    chk_state("full_pop", 1, 1'b1, 1'b1);
    chk_head("full_pop", 32'h8000_0004);

    // Push and pop together at count=1.
    cyc(1'b1, 32'h8000_0010, 1'b1, 1'b0);
    chk_state("pushpop", 1, 1'b1, 1'b1);
    chk_head("pushpop", 32'h8000_0010);

    // Flush with 2 entries and a concurrent push.
    cyc(1'b1, 32'h8000_0014, 1'b0, 1'b0);
    chk_state("preflush", 2, 1'b1, 1'b0);
    cyc(1'b1, 32'h8000_000C, 1'b1, 1'b1);
    chk_state("flush", 0, 1'b0, 1'b1);
    cyc(1'b1, 32'h8000_0018, 1'b0, 1'b0);
    chk_state("postflush", 1, 1'b1, 1'b1);
    chk_head("postflush", 32'h8000_0018);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk_state("drain", 0, 1'b0, 1'b1);

`ifndef FETCH_BUF_BYPASS_EN
    // Streaming across several pointer wraps: head trails each push by one cycle.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 32'h8000_0000 + 32'(4 * i), 1'b1, 1'b0);
      chk_head($sformatf("stream%0d", i), 32'h8000_0000 + 32'(4 * i));
      chk($sformatf("stream%0d.count", i), {30'd0, buf_o_count}, 32'd1);
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk_state("stream_drain", 0, 1'b0, 1'b1);
`endif

    // Asynchronous reset mid-cycle with 2 entries held.
    cyc(1'b1, 32'h8000_0020, 1'b0, 1'b0);
    cyc(1'b1, 32'h8000_0024, 1'b0, 1'b0);
    chk_state("prereset", 2, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_state("async_rst", 0, 1'b0, 1'b1);
    chk("async_rst.pc",     regD_o_pc, 32'd0);
    chk("async_rst.pre_pc", regD_o_pre_pc, 32'd0);
    chk("async_rst.instr",  regD_o_instr, 32'd0);
    chk("async_rst.commit", {31'd0, regD_o_commit}, 32'd0);
    #1 rst = 1'b0;

    cyc(1'b1, 32'h8000_0030, 1'b0, 1'b0);
    chk_state("after_rst", 1, 1'b1, 1'b1);
    chk_head("after_rst", 32'h8000_0030);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
